// File: rtl/updown_decode_pkg.sv
// Shared types and constants for the up/down count decoder.
// Covers FSM states, step classes and the modular step deltas.
package updown_decode_pkg;

    typedef enum logic [1:0] {S_INIT, S_ACQ, S_UP, S_DOWN} state_t;
    typedef enum logic [1:0] {STEP_HOLD, STEP_UP, STEP_DOWN, STEP_ILLEGAL} step_t;

    // Modular difference between consecutive samples for a single up or down step.
    function automatic logic [31:0] DELTA_UP(input int width);
        return (width > 0) ? 32'd1 : 32'd0;
    endfunction

    function automatic logic [31:0] DELTA_DOWN(input int width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/count_step_classify.sv
// Combinational classification of one count transition (prev -> count_in).
// Also flags whether that transition crosses the max/0 boundary.
module count_step_classify
    import updown_decode_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] prev,
    input  logic [WIDTH-1:0] count_in,
    output step_t            step,
    output logic             wrap_q
);
    localparam logic [WIDTH-1:0] D_UP   = WIDTH'(DELTA_UP(WIDTH));
    localparam logic [WIDTH-1:0] D_DOWN = WIDTH'(DELTA_DOWN(WIDTH));
    localparam logic [WIDTH-1:0] MAX    = '1;

    logic [WIDTH-1:0] delta;

    always_comb begin
        delta = count_in - prev;
        step  = STEP_ILLEGAL;
        if (delta == '0)
            step = STEP_HOLD;
        else if (delta == D_UP)
            step = STEP_UP;
        else if (delta == D_DOWN)
            step = STEP_DOWN;
        wrap_q = ((step == STEP_UP) && (prev == MAX)) ||
                 ((step == STEP_DOWN) && (prev == '0));
    end

endmodule

// File: rtl/updown_count_decoder.sv
// Passive monitor on an up/down counter bus: decodes direction and run length,
// and flags wrap, reversal, stall and illegal jumps (err is sticky until rst).
module updown_count_decoder
    import updown_decode_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int HOLD_LIMIT = 8,
    parameter int RUN_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] count_in,
    output logic             dir_up,
    output logic             dir_valid,
    output logic             dir_change,
    output logic             wrap,
    output logic             stall,
    output logic             err,
    output logic [RUN_W-1:0] step_cnt
);
    localparam int               HOLD_W   = $clog2(HOLD_LIMIT + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_LIMIT);
    localparam logic [RUN_W-1:0]  RUN_MAX  = '1;

    state_t            state;
    logic [WIDTH-1:0]  prev;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_nxt;
    logic [RUN_W-1:0]  run_inc;
    step_t             step;
    logic              wrap_q;
    logic              step_up;
    logic              same_dir;

    count_step_classify #(.WIDTH(WIDTH)) u_classify (
        .prev     (prev),
        .count_in (count_in),
        .step     (step),
        .wrap_q   (wrap_q)
    );

    assign hold_nxt = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + HOLD_W'(1);
    assign run_inc  = (step_cnt == RUN_MAX) ? step_cnt : step_cnt + RUN_W'(1);
    assign step_up  = (step == STEP_UP);
    assign same_dir = ((state == S_UP) == step_up);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_INIT;
            prev       <= '0;
            hold_cnt   <= '0;
            dir_up     <= 1'b0;
            dir_valid  <= 1'b0;
            dir_change <= 1'b0;
            wrap       <= 1'b0;
            stall      <= 1'b0;
            err        <= 1'b0;
            step_cnt   <= '0;
        end else begin
            prev       <= count_in;
            dir_change <= 1'b0;
            wrap       <= 1'b0;
            if (state == S_INIT) begin
                // First sample after reset only seeds prev; nothing is classified.
                state <= S_ACQ;
            end else begin
                wrap <= wrap_q;
                if (step == STEP_HOLD) begin
                    hold_cnt <= hold_nxt;
                    stall    <= (hold_nxt == HOLD_MAX);
                end else begin
                    hold_cnt <= '0;
                    stall    <= 1'b0;
                end

                case (step)
                    STEP_UP, STEP_DOWN: begin
                        if (state == S_ACQ) begin
                            state     <= step_up ? S_UP : S_DOWN;
                            dir_up    <= step_up;
                            dir_valid <= 1'b1;
                            step_cnt  <= RUN_W'(1);
                        end else if (same_dir) begin
                            step_cnt <= run_inc;
                        end else begin
                            state      <= step_up ? S_UP : S_DOWN;
                            dir_up     <= step_up;
                            dir_change <= 1'b1;
                            step_cnt   <= RUN_W'(1);
                        end
                    end
                    STEP_ILLEGAL: begin
                        // Resync: drop direction, decode again from the new sample.
                        err       <= 1'b1;
                        dir_valid <= 1'b0;
                        step_cnt  <= '0;
                        state     <= S_ACQ;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/updown_count_decoder.md
Name: updown_count_decoder

Overview:
- Passive observer on the 4-bit up/down counter output bus; recovers count direction from the sampled count sequence alone.
- Flags wrap-around, direction reversals, stalls and illegal jumps.
- Sits beside the counter as the receive-side decoder of its `count` interface; used in-design for status reporting and by benches as a self-checking monitor.

Parameters:
- WIDTH, 4: width of observed count bus.
- HOLD_LIMIT, 8: consecutive unchanged samples before stall asserts (>=1).
- RUN_W, 8: width of run-length counter step_cnt.

Ports:
- clk  input  1  rising-edge clock, same clock as the observed counter.
- rst  input  1  synchronous, active-high reset.
- count_in  input  WIDTH  observed counter value, sampled every rising edge.
- dir_up  output  1  last decoded direction: 1=up, 0=down; meaningful only when dir_valid=1.
- dir_valid  output  1  a legal step has been decoded since last reset/resync.
- dir_change  output  1  one-cycle pulse on reversal of direction.
- wrap  output  1  one-cycle pulse on max->0 (up) or 0->max (down) step.
- stall  output  1  count unchanged for >= HOLD_LIMIT consecutive samples.
- err  output  1  sticky: an illegal jump was seen; cleared only by rst.
- step_cnt  output  RUN_W  legal steps in current direction run; saturates at 2^RUN_W-1.

Behaviour:
- All outputs registered. Reset values: every output 0, state=S_INIT, prev=0, hold_cnt=0.
- rst=1 at any edge, including mid-run or mid-stall, forces reset values on that edge. rst has priority over every other event.
- Step classification (combinational on count_in vs prev), delta = (count_in - prev) mod 2^WIDTH:
  - delta==1 -> UP
  - delta==2^WIDTH-1 -> DOWN
  - delta==0 -> HOLD
  - otherwise -> ILLEGAL
- prev <= count_in on every non-reset edge, in every state.
- Latency: a step between samples at edges n-1 and n is reflected on outputs immediately after edge n.
- States:
  - S_INIT: first post-reset sample only; capture prev; go to S_ACQ. No classification, all outputs stay 0.
  - S_ACQ: no direction yet.
    - UP -> S_UP, dir_up=1, dir_valid=1, step_cnt=1.
    - DOWN -> S_DOWN, dir_up=0, dir_valid=1, step_cnt=1.
    - HOLD -> stay.
    - ILLEGAL -> err=1, stay.
  - S_UP:
    - UP -> step_cnt+1 (saturating).
    - DOWN -> S_DOWN, dir_up=0, dir_change pulse, step_cnt=1.
    - HOLD -> stay, step_cnt held.
    - ILLEGAL -> resync (below).
  - S_DOWN: mirror of S_UP.
- Resync on ILLEGAL in S_UP/S_DOWN: err=1 (sticky), dir_valid=0, step_cnt=0, state -> S_ACQ. The new count_in becomes prev, so decoding resumes from it. No dir_change or wrap pulse on that edge.
- wrap:
  - pulses on an UP step with prev=2^WIDTH-1, or a DOWN step with prev=0.
  - valid in S_ACQ too.
  - wrap and dir_change may pulse on the same edge, e.g. a reversal that crosses 0.
- stall / hold_cnt:
  - HOLD increments hold_cnt, saturating at HOLD_LIMIT.
  - stall = (hold_cnt==HOLD_LIMIT), registered.
  - any UP/DOWN/ILLEGAL clears hold_cnt and stall on that edge.
  - HOLD in S_INIT does not count.
- Pulses (dir_change, wrap) are high exactly one cycle per event.
- X on count_in is not handled; the observed counter must be out of reset first.

Decomposition:
- Package updown_decode_pkg:
  - state enum {S_INIT, S_ACQ, S_UP, S_DOWN}
  - step-class enum {STEP_HOLD, STEP_UP, STEP_DOWN, STEP_ILLEGAL}
  - DELTA_UP / DELTA_DOWN constant functions of WIDTH
- One sub-module, count_step_classify: combinational prev/count_in -> step class plus wrap qualifier.
- Top holds the FSM, prev register, hold counter and run counter.

Test Plan:
- Reset, then count_in 0,1,2...15,0,1 one per cycle:
  - dir_valid=1, dir_up=1 from the edge after 1 is sampled.
  - step_cnt reaches 17.
  - wrap pulses once on the 15->0 edge.
  - err=0.
- From 5 counting up to 8, then 7,6,5:
  - dir_change pulses once on the 8->7 edge; dir_up=0, step_cnt=1 on that edge, then 3 after 5.
  - wrap never pulses.
- Down sequence 2,1,0,15,14:
  - wrap pulses on the 0->15 edge; dir_up=0; step_cnt=4.
- Up run to 6, then count_in held at 6 for 10 cycles:
  - stall asserts after the 8th repeated sample.
  - step_cnt holds.
  - next value 7 clears stall on that edge; step_cnt+1.
- Up run 3,4 then jump to 9, then 10,11:
  - err=1 on the jump edge, dir_valid=0, step_cnt=0.
  - 10 re-enters S_UP with step_cnt=1; 11 gives 2.
  - err stays 1.
- rst=1 for one edge mid-up-run at step_cnt=5:
  - all outputs 0 after that edge.
  - next sample is captured only (S_INIT), with no step or err.
  - err cleared.
